// File: rtl/issue_queue_mp.sv
// In-order multi-port issue queue: up to PUSH_W packets in, oldest POP_W packets out; optional ISSUE_Q_BYPASS_EN.
// Latency: 1 cycle from accept to o_data (0 cycles on an empty queue with ISSUE_Q_BYPASS_EN).
// Backpressure: o_in_ready is all-or-nothing per PUSH_W group from registered count; pops are clamped to occupancy.
module issue_queue_mp #(
  parameter int DEPTH        = 16,
  parameter int W            = 256,
  parameter int PUSH_W       = 2,
  parameter int POP_W        = 2,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [PUSH_W*W-1:0]          i_data,
  input  logic [PUSH_W-1:0]            i_valid,
  output logic                         o_in_ready,
  output logic [POP_W*W-1:0]           o_data,
  output logic [POP_W-1:0]             o_out_valid,
  input  logic [$clog2(POP_W+1)-1:0]   i_pop_num,
  input  logic                         i_stall,
  input  logic                         i_flush,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_afull,
  output logic                         o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int unsigned DEPTH_U  = DEPTH;
  localparam int unsigned PUSH_U   = PUSH_W;
  localparam int unsigned AFULL_U  = AFULL_MARGIN;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  int unsigned   push_n, pop_n, byp_pop, free_n;
  logic          byp_act;

  // Increments never exceed DEPTH, so a single conditional subtract wraps.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= DEPTH_U) s = s - DEPTH_U;
    return PW'(s);
  endfunction

  assign free_n     = DEPTH_U - 32'(count_q);
  assign o_in_ready = free_n >= PUSH_U;
  assign o_afull    = free_n < AFULL_U;
  assign o_empty    = (count_q == '0);
  assign o_count    = count_q;

`ifdef ISSUE_Q_BYPASS_EN
  assign byp_act = (count_q == '0) && !i_flush;
`else
  assign byp_act = 1'b0;
`endif

  always_comb begin
    push_n = 0;
    for (int k = 0; k < PUSH_W; k++)
      if (i_valid[k]) push_n = push_n + 1;
    if (!o_in_ready) push_n = 0;

    pop_n = 0;
    if (!i_stall && !i_flush)
      pop_n = (32'(i_pop_num) < 32'(count_q)) ? 32'(i_pop_num) : 32'(count_q);

    // Lanes consumed straight off the input never occupy storage.
    byp_pop = 0;
    if (byp_act && !i_stall)
      byp_pop = (32'(i_pop_num) < push_n) ? 32'(i_pop_num) : push_n;

    head_d  = wrap_add(head_q, push_n - byp_pop);
    tail_d  = wrap_add(tail_q, pop_n);
    count_d = CW'(32'(count_q) + push_n - byp_pop - pop_n);
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (!i_flush)
        for (int unsigned k = 0; k < PUSH_U; k++)
          if (k >= byp_pop && k < push_n)
            mem_q[wrap_add(head_q, k - byp_pop)] <= i_data[k*W +: W];
    end
  end

  for (genvar k = 0; k < POP_W; k++) begin : g_out
    logic [W-1:0] st_dat;
    logic         st_vld;
    assign st_dat = mem_q[wrap_add(tail_q, k)];
    assign st_vld = count_q > CW'(k);
    if (k < PUSH_W) begin : g_byp
      assign o_data[k*W +: W] = byp_act ? i_data[k*W +: W] : st_dat;
      assign o_out_valid[k]   = byp_act ? (i_valid[k] & o_in_ready) : st_vld;
    end else begin : g_st
      assign o_data[k*W +: W] = st_dat;
      assign o_out_valid[k]   = st_vld;
    end
  end

`ifdef SIM
  a_valid_contig: assert property (@(posedge clk) disable iff (!rstn)
    ((i_valid & (i_valid + 1'b1)) == '0));
`endif

endmodule

// File: tb/tb_issue_queue_mp.sv
// Scoreboard bench for issue_queue_mp: a DEPTH=16 instance for directed flow tests and a DEPTH=5 instance for wrap.
module tb_issue_queue_mp;
  localparam int W = 32;
`ifdef ISSUE_Q_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic [2*W-1:0] a_data, a_odata;
  logic [1:0]     a_valid, a_ovld, a_popn;
  logic           a_rdy, a_stall, a_flush, a_afull, a_empty;
  logic [4:0]     a_cnt;

  logic [2*W-1:0] b_data, b_odata;
  logic [1:0]     b_valid, b_ovld, b_popn;
  logic           b_rdy, b_afull, b_empty;
  logic [2:0]     b_cnt;

  issue_queue_mp #(.DEPTH(16), .W(W), .PUSH_W(2), .POP_W(2), .AFULL_MARGIN(4)) u_dut (
    .clk(clk), .rstn(rstn), .i_data(a_data), .i_valid(a_valid), .o_in_ready(a_rdy),
    .o_data(a_odata), .o_out_valid(a_ovld), .i_pop_num(a_popn), .i_stall(a_stall),
    .i_flush(a_flush), .o_count(a_cnt), .o_afull(a_afull), .o_empty(a_empty));

  issue_queue_mp #(.DEPTH(5), .W(W), .PUSH_W(2), .POP_W(2), .AFULL_MARGIN(1)) u_dut5 (
    .clk(clk), .rstn(rstn), .i_data(b_data), .i_valid(b_valid), .o_in_ready(b_rdy),
    .o_data(b_odata), .o_out_valid(b_ovld), .i_pop_num(b_popn), .i_stall(1'b0),
    .i_flush(1'b0), .o_count(b_cnt), .o_afull(b_afull), .o_empty(b_empty));

  int checks = 0;
  int errors = 0;
  logic [31:0] expa[$];
  logic [31:0] expb[$];
  int mcnt = 0;
  int mcnt_next = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: each popped lane must match the oldest outstanding expected packet.
  always @(negedge clk) begin
    if (rstn && !a_stall && !a_flush)
      for (int k = 0; k < 2; k++)
        if (k < int'(a_popn) && a_ovld[k]) begin
          if (expa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_extra: lane %0d data %0h, expected no entry", k, a_odata[k*W +: W]);
          end else chk("a_order", a_odata[k*W +: W], expa.pop_front());
        end
  end

  always @(negedge clk) begin
    if (rstn)
      for (int k = 0; k < 2; k++)
        if (k < int'(b_popn) && b_ovld[k]) begin
          if (expb.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_extra: lane %0d data %0h, expected no entry", k, b_odata[k*W +: W]);
          end else chk("b_order", b_odata[k*W +: W], expb.pop_front());
        end
  end

  // Drive one cycle of stimulus on the DEPTH=16 queue and predict its effect.
  task automatic drive_a(input int nv, input logic [31:0] pc0, input int popn, input bit stall, input bit flush);
    int pushed, p;
    a_valid = (nv == 0) ? 2'b00 : (nv == 1) ? 2'b01 : 2'b11;
    a_data  = {pc0 + 32'd4, pc0};
    a_popn  = 2'(popn);
    a_stall = stall;
    a_flush = flush;
    pushed  = ((16 - mcnt) >= 2) ? nv : 0;
    if (flush) begin
      expa.delete();
      mcnt_next = 0;
    end else begin
      for (int k = 0; k < pushed; k++) expa.push_back(pc0 + 32'(4 * k));
      if (stall) p = 0;
      else if (BYP && mcnt == 0) p = (popn < pushed) ? popn : pushed;
      else p = (popn < mcnt) ? popn : mcnt;
      mcnt_next = mcnt + pushed - p;
    end
  endtask

  task automatic tick_a();
    @(posedge clk); #1;
    mcnt = mcnt_next;
  endtask

  task automatic step_a(input int nv, input logic [31:0] pc0, input int popn, input bit stall, input bit flush);
    drive_a(nv, pc0, popn, stall, flush);
    tick_a();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    rstn = 1'b0;
    a_data = '0; a_valid = '0; a_popn = '0; a_stall = 1'b0; a_flush = 1'b0;
    b_data = '0; b_valid = '0; b_popn = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", a_ovld, 2'b00);
    chk("rst_empty", a_empty, 1'b1);
    chk("rst_count", a_cnt, 0);
    chk("rst_afull", a_afull, 1'b0);
    chk("rst_ready", a_rdy, 1'b1);
    rstn = 1'b1;
    @(posedge clk); #1;

    // First double push becomes visible one cycle later.
    step_a(2, 32'h1c000000, 0, 0, 0);
    chk("p2_valid", a_ovld, 2'b11);
    chk("p2_count", a_cnt, 2);
    chk("p2_lane0", a_odata[W-1:0], 32'h1c000000);
    step_a(0, 0, 2, 0, 0);
    chk("p2_drained", a_empty, 1'b1);

    // Fill to DEPTH, then a rejected ninth push.
    for (int i = 0; i < 8; i++) begin
      step_a(2, 32'h20000000 + 32'(8 * i), 0, 0, 0);
      chk("fill_count", a_cnt, 32'(2 * (i + 1)));
      chk("fill_afull", a_afull, (2 * (i + 1) >= 13) ? 1'b1 : 1'b0);
    end
    chk("full_ready", a_rdy, 1'b0);
    step_a(2, 32'h2f000000, 0, 0, 0);
    chk("full_count", a_cnt, 16);
    for (int i = 0; i < 8; i++) step_a(0, 0, 2, 0, 0);
    chk("full_drained", a_cnt, 0);

    // Clamped pop: one entry, ask for two.
    step_a(1, 32'h30000000, 0, 0, 0);
    chk("clamp_pre", a_cnt, 1);
    step_a(0, 0, 2, 0, 0);
    chk("clamp_count", a_cnt, 0);
    chk("clamp_empty", a_empty, 1'b1);
    step_a(2, 32'h30000100, 0, 0, 0);
    chk("clamp_lane0", a_odata[W-1:0], 32'h30000100);
    chk("clamp_lane1", a_odata[2*W-1:W], 32'h30000104);
    step_a(0, 0, 2, 0, 0);

    // Stall holds the pop side while pushes accumulate; flush wins over a push.
    step_a(2, 32'h40000000, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step_a(2, 32'h40000100 + 32'(8 * i), 2, 1, 0);
      chk("stall_count", a_cnt, 32'(4 + 2 * i));
      chk("stall_lane0", a_odata[W-1:0], 32'h40000000);
    end
    step_a(2, 32'h4f000000, 0, 0, 1);
    chk("flush_count", a_cnt, 0);
    chk("flush_valid", a_ovld, 2'b00);

    // Empty-queue push with same-cycle pop request.
    drive_a(2, 32'h50000000, 2, 0, 0);
    #1;
    chk("byp_valid", a_ovld, BYP ? 2'b11 : 2'b00);
    if (BYP) chk("byp_lane0", a_odata[W-1:0], 32'h50000000);
    tick_a();
    chk("byp_count", a_cnt, BYP ? 0 : 2);
    step_a(0, 0, 2, 0, 0);
    chk("byp_end_empty", a_empty, 1'b1);
    drive_a(0, 0, 0, 0, 0);

    // DEPTH=5 pointer wrap: steady push/pop of two per cycle.
    pc = 32'h1c000000;
    for (int i = 0; i < 20; i++) begin
      b_data = {pc + 32'd4, pc};
      b_valid = 2'b11;
      b_popn = 2'd2;
      expb.push_back(pc);
      expb.push_back(pc + 32'd4);
      @(posedge clk); #1;
      chk("wrap_count", b_cnt, BYP ? 0 : 2);
      pc = pc + 32'd8;
    end
    b_valid = 2'b00;
    @(posedge clk); #1;
    chk("wrap_empty", b_empty, 1'b1);
    b_popn = 2'd0;

    @(posedge clk); #1;
    chk("a_drained", 32'(expa.size()), 0);
    chk("b_drained", 32'(expb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
